// File: rtl/mp_regfile_pkg.sv
// mp_regfile_pkg: shared defaults, register-address type and register-zero helpers
// for the mp_regfile register file and its read ports.
package mp_regfile_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int NREG_DEFAULT = 32;
  localparam int NRD_DEFAULT  = 2;
  localparam int NWR_DEFAULT  = 2;
  localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);

  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

  localparam int unsigned REG_ZERO = 32'd0;

  function automatic logic is_reg_zero(input int unsigned idx);
    return (idx == REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one read port of mp_regfile (array mux plus optional forwarding).
// Forwarding from same-cycle writes is compiled in when REGFILE_BYPASS_EN is defined.
module rf_read_port
  import mp_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
`ifdef REGFILE_BYPASS_EN
  parameter int NWR  = NWR_DEFAULT,
`endif
  localparam int AW  = $clog2(NREG)
) (
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] regs [NREG],
  input  logic [NREG-1:0] busy,
`ifdef REGFILE_BYPASS_EN
  input  logic            wr_en   [NWR],
  input  logic [AW-1:0]   wr_addr [NWR],
  input  logic [XLEN-1:0] wr_data [NWR],
`endif
  output logic [XLEN-1:0] rd_data,
  output logic            rd_busy
);

  // Registered view first; when forwarding, the highest matching write port overrides it.
  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NWR; w++) begin
      rd_data = (wr_en[w] && (wr_addr[w] == rd_addr) && !is_reg_zero(32'(rd_addr)))
                ? wr_data[w] : rd_data;
      rd_busy = (wr_en[w] && (wr_addr[w] == rd_addr) && !is_reg_zero(32'(rd_addr)))
                ? 1'b0 : rd_busy;
    end
`endif
  end

endmodule

// File: rtl/mp_regfile.sv
// mp_regfile: multi-port register file with a single-bit-per-register issue scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module mp_regfile
  import mp_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int NRD  = NRD_DEFAULT,
  parameter int NWR  = NWR_DEFAULT,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rd_addr  [NRD],
  output logic [XLEN-1:0] rd_data  [NRD],
  output logic            rd_busy  [NRD],
  input  logic            wr_en    [NWR],
  input  logic [AW-1:0]   wr_addr  [NWR],
  input  logic [XLEN-1:0] wr_data  [NWR],
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  output logic [XLEN-1:0] regs_o   [NREG],
  output logic [NREG-1:0] busy_o
);

  logic [XLEN-1:0] regs_r [NREG];
  logic [NREG-1:0] busy_r;

  // Later ports override earlier ones; an issue overrides a same-cycle write clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
      busy_r <= {NREG{1'b0}};
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && !is_reg_zero(32'(wr_addr[w]))) begin
          regs_r[wr_addr[w]] <= wr_data[w];
          busy_r[wr_addr[w]] <= 1'b0;
        end
      end
      if (iss_en && !is_reg_zero(32'(iss_addr))) begin
        busy_r[iss_addr] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    rf_read_port #(
      .XLEN (XLEN),
`ifdef REGFILE_BYPASS_EN
      .NWR  (NWR),
`endif
      .NREG (NREG)
    ) u_port (
      .rd_addr (rd_addr[p]),
      .regs    (regs_r),
      .busy    (busy_r),
`ifdef REGFILE_BYPASS_EN
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
`endif
      .rd_data (rd_data[p]),
      .rd_busy (rd_busy[p])
    );
  end

  assign regs_o = regs_r;
  assign busy_o = busy_r;

endmodule

// File: tb/tb_mp_regfile.sv
// tb_mp_regfile: directed scenarios plus random traffic against an array-based model,
// checked through a scoreboard queue drained by an independent monitor.
module tb_mp_regfile;

  localparam int XLEN = 64;
  localparam int NREG = 16;
  localparam int NRD  = 4;
  localparam int NWR  = 4;
  localparam int AW   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   rd_addr  [NRD];
  logic [XLEN-1:0] rd_data  [NRD];
  logic            rd_busy  [NRD];
  logic            wr_en    [NWR];
  logic [AW-1:0]   wr_addr  [NWR];
  logic [XLEN-1:0] wr_data  [NWR];
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic [XLEN-1:0] regs_o   [NREG];
  logic [NREG-1:0] busy_o;

  always #5 clk = ~clk;

  mp_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .regs_o(regs_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [NRD-1:0][XLEN-1:0]  rd_data;
    logic [NRD-1:0]            rd_busy;
    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           busy;
    bit                        has_k;
    logic [XLEN-1:0]           k_data;
    logic                      k_busy;
    int                        cyc;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];

  bit              k_en = 1'b0;
  logic [XLEN-1:0] k_data = 64'd0;
  logic            k_busy = 1'b0;

  function automatic void model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = 64'd0;
      m_busy[r] = 1'b0;
    end
  endfunction

  function automatic void model_read(input int a, output logic [XLEN-1:0] d, output logic b);
    d = m_regs[a];
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (a != 0) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && int'(wr_addr[w]) == a) begin
          d = wr_data[w];
          b = 1'b0;
        end
      end
    end
`endif
  endfunction

  // Per register: the last enabled port targeting it supplies the data; an issue re-marks it.
  function automatic void model_commit();
    for (int r = 1; r < NREG; r++) begin
      int win = -1;
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && int'(wr_addr[w]) == r) win = w;
      end
      if (win >= 0) begin
        m_regs[r] = wr_data[win];
        m_busy[r] = 1'b0;
      end
      if (iss_en && int'(iss_addr) == r) m_busy[r] = 1'b1;
    end
  endfunction

  task automatic clear_inputs();
    for (int p = 0; p < NRD; p++) rd_addr[p] = 4'd0;
    for (int w = 0; w < NWR; w++) begin
      wr_en[w] = 1'b0;
      wr_addr[w] = 4'd0;
      wr_data[w] = 64'd0;
    end
    iss_en = 1'b0;
    iss_addr = 4'd0;
  endtask

  task automatic expect_k(input logic [XLEN-1:0] d, input logic b);
    k_en = 1'b1;
    k_data = d;
    k_busy = b;
  endtask

  task automatic step();
    exp_t e;
    logic [XLEN-1:0] d;
    logic b;
    if (!rst_n) model_clear();
    for (int p = 0; p < NRD; p++) begin
      model_read(int'(rd_addr[p]), d, b);
      e.rd_data[p] = d;
      e.rd_busy[p] = b;
    end
    for (int r = 0; r < NREG; r++) begin
      e.regs[r] = m_regs[r];
      e.busy[r] = m_busy[r];
    end
    e.has_k = k_en;
    e.k_data = k_data;
    e.k_busy = k_busy;
    e.cyc = cyc;
    sb_q.push_back(e);
    k_en = 1'b0;
    @(posedge clk);
    if (rst_n) model_commit();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input exp_t e);
    int bad;
    for (int p = 0; p < NRD; p++) begin
      tests++;
      if (rd_data[p] !== e.rd_data[p]) begin
        fails++;
        $display("FAIL rd_data[%0d] cyc %0d: got %h want %h", p, e.cyc, rd_data[p], e.rd_data[p]);
      end
      tests++;
      if (rd_busy[p] !== e.rd_busy[p]) begin
        fails++;
        $display("FAIL rd_busy[%0d] cyc %0d: got %b want %b", p, e.cyc, rd_busy[p], e.rd_busy[p]);
      end
    end
    tests++;
    bad = -1;
    for (int r = NREG - 1; r >= 0; r--) begin
      if (regs_o[r] !== e.regs[r]) bad = r;
    end
    if (bad >= 0) begin
      fails++;
      $display("FAIL regs_o[%0d] cyc %0d: got %h want %h", bad, e.cyc, regs_o[bad], e.regs[bad]);
    end
    tests++;
    if (busy_o !== e.busy) begin
      fails++;
      $display("FAIL busy_o cyc %0d: got %h want %h", e.cyc, busy_o, e.busy);
    end
    if (e.has_k) begin
      tests++;
      if (rd_data[0] !== e.k_data) begin
        fails++;
        $display("FAIL directed_data cyc %0d: got %h want %h", e.cyc, rd_data[0], e.k_data);
      end
      tests++;
      if (rd_busy[0] !== e.k_busy) begin
        fails++;
        $display("FAIL directed_busy cyc %0d: got %b want %b", e.cyc, rd_busy[0], e.k_busy);
      end
    end
  endtask

  // Monitor: samples mid-low-phase, after the driver has applied this cycle's inputs.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    model_clear();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    expect_k(64'd0, 1'b0);
    step();
    rst_n = 1'b1;

    // Same-address write conflict: highest port wins
    clear_inputs();
    wr_en[0] = 1'b1; wr_addr[0] = 4'd5; wr_data[0] = 64'h11;
    wr_en[1] = 1'b1; wr_addr[1] = 4'd5; wr_data[1] = 64'h22;
    step();
    clear_inputs(); rd_addr[0] = 4'd5; expect_k(64'h22, 1'b0);
    step();

    // Register zero ignores writes and issues
    clear_inputs();
    wr_en[0] = 1'b1; wr_addr[0] = 4'd0; wr_data[0] = 64'hDEAD;
    iss_en = 1'b1; iss_addr = 4'd0;
    expect_k(64'd0, 1'b0);
    step();
    clear_inputs(); expect_k(64'd0, 1'b0);
    step();

    // Scoreboard issue / write sequence on x7
    clear_inputs(); iss_en = 1'b1; iss_addr = 4'd7;
    step();
    clear_inputs(); rd_addr[0] = 4'd7; expect_k(64'd0, 1'b1);
    step();
    clear_inputs(); rd_addr[0] = 4'd7; expect_k(64'd0, 1'b1);
    step();
    clear_inputs(); rd_addr[0] = 4'd7;
    wr_en[2] = 1'b1; wr_addr[2] = 4'd7; wr_data[2] = 64'h5;
`ifdef REGFILE_BYPASS_EN
    expect_k(64'h5, 1'b0);
`else
    expect_k(64'd0, 1'b1);
`endif
    step();
    clear_inputs(); rd_addr[0] = 4'd7; expect_k(64'h5, 1'b0);
    step();
    clear_inputs(); rd_addr[0] = 4'd7;
    iss_en = 1'b1; iss_addr = 4'd7;
    wr_en[3] = 1'b1; wr_addr[3] = 4'd7; wr_data[3] = 64'h9;
`ifdef REGFILE_BYPASS_EN
    expect_k(64'h9, 1'b0);
`else
    expect_k(64'h5, 1'b0);
`endif
    step();
    clear_inputs(); rd_addr[0] = 4'd7; expect_k(64'h9, 1'b1);
    step();

    // Write and read x3 in the same cycle
    clear_inputs(); rd_addr[0] = 4'd3;
    wr_en[1] = 1'b1; wr_addr[1] = 4'd3; wr_data[1] = 64'hABCD;
`ifdef REGFILE_BYPASS_EN
    expect_k(64'hABCD, 1'b0);
`else
    expect_k(64'd0, 1'b0);
`endif
    step();
    clear_inputs(); rd_addr[0] = 4'd3; expect_k(64'hABCD, 1'b0);
    step();

    // Mid-run reset with live state; traffic during reset must be dropped
    clear_inputs(); rst_n = 1'b0; rd_addr[0] = 4'd5; expect_k(64'd0, 1'b0);
    wr_en[0] = 1'b1; wr_addr[0] = 4'd9; wr_data[0] = 64'h77;
    iss_en = 1'b1; iss_addr = 4'd9;
    step();
    clear_inputs(); rd_addr[0] = 4'd7; expect_k(64'd0, 1'b0);
    iss_en = 1'b1; iss_addr = 4'd9;
    wr_en[1] = 1'b1; wr_addr[1] = 4'd9; wr_data[1] = 64'h78;
    step();
    rst_n = 1'b1;
    clear_inputs(); rd_addr[0] = 4'd9; expect_k(64'd0, 1'b0);
    step();

    // Random traffic with frequent address collisions and rare resets
    for (int i = 0; i < 10000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      for (int w = 0; w < NWR; w++) begin
        wr_en[w] = 1'($urandom_range(0, 1));
        wr_addr[w] = AW'($urandom_range(0, NREG - 1));
        if ($urandom_range(0, 3) == 0) wr_addr[w] = wr_addr[0];
        wr_data[w] = {$urandom, $urandom};
      end
      iss_en = 1'($urandom_range(0, 1));
      iss_addr = AW'($urandom_range(0, NREG - 1));
      if ($urandom_range(0, 3) == 0) iss_addr = wr_addr[1];
      for (int p = 0; p < NRD; p++) begin
        rd_addr[p] = AW'($urandom_range(0, NREG - 1));
        if ($urandom_range(0, 2) == 0) rd_addr[p] = wr_addr[$urandom_range(0, NWR - 1)];
      end
      step();
    end
    rst_n = 1'b1;
    clear_inputs();

    repeat (2) @(negedge clk);
    #4;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
